// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Brief    : Shared RV32I constants, fetch state encoding and fault codes.
// Revision : 1.0
// ============================================================================
package rv32i_pkg;

    localparam int RV_XLEN     = 32;
    localparam int RV_REG_BITS = 5;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_WAIT  = S_WAIT,
        ST_DRAIN = S_DRAIN,
        ST_FAULT = S_FAULT
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rv32i_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_fetch
// Brief    : Instruction fetch unit: one outstanding memory read with
//            flush, misalignment and timeout handling.
// Revision : 1.0
// ============================================================================
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter int XLEN    = RV_XLEN,
    parameter int ILEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            fetch_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_read_o,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            mem_ready_i,
    output logic [ILEN-1:0] instruction_o,
    output logic            instruction_valid_o,
    output logic            busy_o,
    output logic [1:0]      fault_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_addr,  w_addr_nxt;
    logic            r_read,  w_read_nxt;
    logic [ILEN-1:0] r_instr, w_instr_nxt;
    logic            r_valid, w_valid_nxt;
    logic [1:0]      r_fault, w_fault_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic            w_timeout;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= FAULT_NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_read  <= w_read_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_fault <= w_fault_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_read_nxt  = r_read;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_fault_nxt = r_fault;
        w_cnt_nxt   = r_cnt;
        // This is the TIMEOUT-th consecutive cycle without ready.
        w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

        case (r_state)
            ST_IDLE, ST_FAULT: begin
                if (flush_i) begin
                    w_valid_nxt = 1'b0;
                    w_fault_nxt = FAULT_NONE;
                    w_state_nxt = ST_IDLE;
                end else if (fetch_i) begin
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    if (pc_i[1:0] == 2'b00) begin
                        w_addr_nxt  = pc_i;
                        w_read_nxt  = 1'b1;
                        w_fault_nxt = FAULT_NONE;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_fault_nxt = FAULT_MISALIGN;
                        w_state_nxt = ST_FAULT;
                    end
                end
            end

            ST_WAIT: begin
                if (mem_ready_i) begin
                    w_read_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (!flush_i) begin
                        w_instr_nxt = mem_data_i[ILEN-1:0];
                        w_valid_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_read_nxt  = 1'b0;
                    w_state_nxt = flush_i ? ST_IDLE : ST_FAULT;
                    w_fault_nxt = flush_i ? FAULT_NONE : FAULT_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (flush_i) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Read stays asserted until the abandoned response lands.
                if (mem_ready_i || w_timeout) begin
                    w_read_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_read_nxt  = 1'b0;
            end
        endcase
    end

    assign mem_addr_o          = r_addr;
    assign mem_read_o          = r_read;
    assign instruction_o       = r_instr;
    assign instruction_valid_o = r_valid;
    assign fault_o             = r_fault;
    assign busy_o              = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_fetch
// Brief    : Directed self-checking bench for rv32i_fetch with a queue of
//            expected instructions.
// Revision : 1.0
// ============================================================================
module tb_rv32i_fetch;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic [31:0] mem_addr_o;
    logic        mem_read_o;
    logic [31:0] mem_data_i;
    logic        mem_ready_i;
    logic [31:0] instruction_o;
    logic        instruction_valid_o;
    logic        busy_o;
    logic [1:0]  fault_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic        prev_valid = 1'b0;

    rv32i_fetch #(
        .XLEN    (32),
        .ILEN    (32),
        .TIMEOUT (15)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .fetch_i             (fetch_i),
        .flush_i             (flush_i),
        .pc_i                (pc_i),
        .mem_addr_o          (mem_addr_o),
        .mem_read_o          (mem_read_o),
        .mem_data_i          (mem_data_i),
        .mem_ready_i         (mem_ready_i),
        .instruction_o       (instruction_o),
        .instruction_valid_o (instruction_valid_o),
        .busy_o              (busy_o),
        .fault_o             (fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Every rising edge of instruction_valid_o must deliver the oldest expected word.
    always @(negedge clk_i) begin
        if (instruction_valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", instruction_o, 32'hxxxx_xxxx);
            end else begin
                check("scoreboard_instr", instruction_o, exp_q.pop_front());
            end
        end
        prev_valid = instruction_valid_o;
    end

    initial begin
        reset_i     = 1'b1;
        fetch_i     = 1'b0;
        flush_i     = 1'b0;
        pc_i        = '0;
        mem_data_i  = '0;
        mem_ready_i = 1'b0;
        tick();
        tick();
        check("rst_read",  {31'b0, mem_read_o}, 32'd0);
        check("rst_addr",  mem_addr_o, 32'd0);
        check("rst_instr", instruction_o, 32'd0);
        check("rst_valid", {31'b0, instruction_valid_o}, 32'd0);
        check("rst_busy",  {31'b0, busy_o}, 32'd0);
        check("rst_fault", {30'b0, fault_o}, 32'd0);
        reset_i = 1'b0;
        tick();

        // Aligned fetch, ready three cycles after the request.
        pc_i = 32'h100; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        check("w_read",  {31'b0, mem_read_o}, 32'd1);
        check("w_addr",  mem_addr_o, 32'h100);
        check("w_busy",  {31'b0, busy_o}, 32'd1);
        check("w_valid", {31'b0, instruction_valid_o}, 32'd0);
        pc_i = 32'h500; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        check("w_ignore_fetch_addr", mem_addr_o, 32'h100);
        tick();
        check("w_hold_read", {31'b0, mem_read_o}, 32'd1);
        check("w_hold_addr", mem_addr_o, 32'h100);
        mem_ready_i = 1'b1; mem_data_i = 32'h0050_0093;
        exp_q.push_back(32'h0050_0093);
        tick();
        mem_ready_i = 1'b0; mem_data_i = '0;
        check("done_valid", {31'b0, instruction_valid_o}, 32'd1);
        check("done_instr", instruction_o, 32'h0050_0093);
        check("done_read",  {31'b0, mem_read_o}, 32'd0);
        check("done_busy",  {31'b0, busy_o}, 32'd0);
        tick();
        check("hold_valid", {31'b0, instruction_valid_o}, 32'd1);
        check("hold_instr", instruction_o, 32'h0050_0093);

        // Misaligned pc, then recovery straight out of FAULT.
        pc_i = 32'h102; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        check("mis_fault", {30'b0, fault_o}, 32'd1);
        check("mis_read",  {31'b0, mem_read_o}, 32'd0);
        check("mis_busy",  {31'b0, busy_o}, 32'd0);
        tick();
        check("mis_fault_hold", {30'b0, fault_o}, 32'd1);
        check("mis_read_hold",  {31'b0, mem_read_o}, 32'd0);
        pc_i = 32'h104; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        check("rec_fault", {30'b0, fault_o}, 32'd0);
        check("rec_read",  {31'b0, mem_read_o}, 32'd1);
        check("rec_addr",  mem_addr_o, 32'h104);
        mem_ready_i = 1'b1; mem_data_i = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        tick();
        mem_ready_i = 1'b0;
        check("rec_instr", instruction_o, 32'h1234_5678);

        // No ready: fault after exactly 15 WAIT cycles.
        pc_i = 32'h200; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("to_busy_14",  {31'b0, busy_o}, 32'd1);
        check("to_read_14",  {31'b0, mem_read_o}, 32'd1);
        check("to_fault_14", {30'b0, fault_o}, 32'd0);
        tick();
        check("to_fault", {30'b0, fault_o}, 32'd2);
        check("to_read",  {31'b0, mem_read_o}, 32'd0);
        check("to_busy",  {31'b0, busy_o}, 32'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_fault_clr", {30'b0, fault_o}, 32'd0);

        // Flush one cycle after fetch: late data is dropped.
        pc_i = 32'h300; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("drain_busy",  {31'b0, busy_o}, 32'd1);
        check("drain_read",  {31'b0, mem_read_o}, 32'd1);
        check("drain_valid", {31'b0, instruction_valid_o}, 32'd0);
        mem_ready_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        tick();
        mem_ready_i = 1'b0;
        check("drain_end_valid", {31'b0, instruction_valid_o}, 32'd0);
        check("drain_end_busy",  {31'b0, busy_o}, 32'd0);
        check("drain_end_read",  {31'b0, mem_read_o}, 32'd0);
        pc_i = 32'h304; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        check("post_drain_addr", mem_addr_o, 32'h304);
        mem_ready_i = 1'b1; mem_data_i = 32'h0000_0013;
        exp_q.push_back(32'h0000_0013);
        tick();
        mem_ready_i = 1'b0;
        check("post_drain_valid", {31'b0, instruction_valid_o}, 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("idle_flush_valid", {31'b0, instruction_valid_o}, 32'd0);

        // Flush and ready together: flush wins.
        pc_i = 32'h400; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0; flush_i = 1'b1; mem_ready_i = 1'b1; mem_data_i = 32'hCAFE_F00D;
        tick();
        flush_i = 1'b0; mem_ready_i = 1'b0;
        check("fr_valid", {31'b0, instruction_valid_o}, 32'd0);
        check("fr_busy",  {31'b0, busy_o}, 32'd0);
        check("fr_read",  {31'b0, mem_read_o}, 32'd0);

        // Asynchronous reset mid-WAIT, then a stray ready.
        pc_i = 32'h600; fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        check("ar_pre_read", {31'b0, mem_read_o}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check("ar_read",  {31'b0, mem_read_o}, 32'd0);
        check("ar_addr",  mem_addr_o, 32'd0);
        check("ar_busy",  {31'b0, busy_o}, 32'd0);
        check("ar_fault", {30'b0, fault_o}, 32'd0);
        #1 reset_i = 1'b0;
        tick();
        mem_ready_i = 1'b1; mem_data_i = 32'h1111_1111;
        tick();
        mem_ready_i = 1'b0;
        check("stray_valid", {31'b0, instruction_valid_o}, 32'd0);
        check("stray_instr", instruction_o, 32'd0);
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
